bus_arbiter_rr: RTL and testbench
=================================

Name: bus_arbiter_rr

Overview:
- N-master to 1-slave bus arbiter; generalised successor of the fixed 2x1 arbiter; sits between the per-hart BUS bridges and the single external bus of a multi-hart top.
- Round-robin fairness; request fields latched at grant; one outstanding transaction at a time; per-master ack/read-data steering.

Parameters:
- NUM_MASTERS, 2, number of requesting buses (>=1).
- XLEN, 32, data and address width.
- TIMEOUT_CYCLES, 256, slave-ack watchdog limit (used only with the optional feature).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset; asynchronous assert, active-low (0 = reset).
- i_bus_en  in  NUM_MASTERS  per-master request.
- i_wr_rd  in  NUM_MASTERS  per-master 1=write, 0=read.
- i_wr_data  in  NUM_MASTERS*XLEN  flattened write data; master k at [k*XLEN +: XLEN].
- i_addr  in  NUM_MASTERS*XLEN  flattened address.
- i_size  in  NUM_MASTERS*3  flattened access size (f3 encoding).
- o_ack  out  NUM_MASTERS  per-master completion pulse.
- o_rd_data  out  NUM_MASTERS*XLEN  per-master read data, valid with o_ack.
- o_grant  out  NUM_MASTERS  one-hot current grant (0 when idle).
- i_ack  in  1  slave completion.
- i_rd_data  in  XLEN  slave read data.
- o_bus_en, o_wr_rd  out  1  slave request, direction.
- o_wr_data, o_addr  out  XLEN  slave write data, address.
- o_size  out  3  slave size.
- o_err  out  1  timeout pulse (tied 0 without feature).

Behaviour:
- Reset: all outputs 0; state IDLE; last-grant pointer = NUM_MASTERS-1, so master 0 wins first.
- States: IDLE, BUSY.
- IDLE: if any i_bus_en, pick first requester searching from (pointer+1) mod NUM_MASTERS upward with wrap.
  - Next edge: latch that master's wr_rd/wr_data/addr/size; set o_grant one-hot; pointer := winner; go BUSY.
  - Request-to-o_bus_en latency: 1 cycle.
- BUSY: o_bus_en=1; slave outputs driven from latched fields only, never live inputs.
- Completion, i_ack=1 in BUSY:
  - o_ack[g]=1 combinationally in the same cycle; o_rd_data slice g = i_rd_data; all other slices 0.
  - Next edge: go IDLE; o_grant=0; o_bus_en=0.
  - One dead IDLE cycle between transactions.
- i_ack while IDLE: ignored; no o_ack.
- Granted master drops i_bus_en mid-transaction: transaction still completes and its ack is still delivered.
- Simultaneous requests: served in rotation. A master holding i_bus_en continuously gets at most one grant per full rotation while others request.
- NUM_MASTERS=1: grant always master 0; same timing.
- Async reset mid-BUSY: outputs clear immediately; the pending slave ack is discarded.

Optional Feature:
- ARBITER_TIMEOUT_EN.
- Defined:
  - Counter cleared on entering BUSY; increments each BUSY cycle without i_ack.
  - When it reaches TIMEOUT_CYCLES-1 and i_ack=0: o_err=1 and o_ack[g]=1 for one cycle, o_rd_data slice g = 0; next edge go IDLE.
  - i_ack in that same cycle wins: normal completion, no o_err.
- Undefined: no counter; o_err constant 0; BUSY waits indefinitely.

Decomposition:
- Shared package/defines: XLEN, f3 size encodings, bus state encodings (IDLE/BUSY).
- One sub-module: rr_picker, purely combinational. Inputs: request vector, pointer. Outputs: one-hot winner and its index.
- FSM, latches, steering and watchdog stay in bus_arbiter_rr.

Test Plan:
- Reset release, master 0 read addr 0x100, slave acks after 3 cycles with 0xDEADBEEF -> o_bus_en high 1 cycle after request; o_addr=0x100; o_ack[0] with o_rd_data[31:0]=0xDEADBEEF; slice 1 = 0.
- NUM_MASTERS=4, all request continuously, slave acks each next cycle -> grant order 0,1,2,3,0; one idle cycle between grants.
- Master 2 writes 0x55 to 0x200 and drops i_bus_en while BUSY; master 2 changes i_addr to 0x300 -> slave still sees o_addr=0x200 and o_wr_data=0x55; o_ack[2] delivered.
- Slave i_ack pulse during IDLE -> no o_ack bit set; state stays IDLE.
- i_rst driven low mid-BUSY -> o_bus_en, o_grant and o_ack drop immediately; after release, master 0 wins first.
- ARBITER_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never acks -> o_err and o_ack[g] pulse 8 cycles after grant, o_rd_data slice g = 0; next requester granted afterwards.

Source files
------------

// File: rtl/bus_arbiter_rr_pkg.sv
// Shared definitions for the round-robin bus arbiter: default data width,
// f3 access-size encodings, bus state encoding and an index-width helper.
package bus_arbiter_rr_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int F3_W         = 3;

  // RISC-V style f3 load/store size field carried through unchanged
  typedef enum logic [F3_W-1:0] {
    F3_BYTE   = 3'b000,
    F3_HALF   = 3'b001,
    F3_WORD   = 3'b010,
    F3_BYTE_U = 3'b100,
    F3_HALF_U = 3'b101
  } f3_size_e;

  // Arbiter bus state: IDLE waits for requests, BUSY owns the slave
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } bus_state_e;

  // Width of a master index; a single master still gets a 1-bit index
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_rr_picker.sv
// Combinational round-robin picker: scans the request vector starting just
// after the last-granted index and wrapping, returning the first requester
// as a one-hot vector plus its index.
module rr_picker
  import bus_arbiter_rr_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int IDX_W       = idx_width(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       ptr,
  output logic [NUM_MASTERS-1:0] winner_onehot,
  output logic [IDX_W-1:0]       winner_idx,
  output logic                   winner_valid
);

  // Search offsets 1..NUM_MASTERS from the pointer; offset NUM_MASTERS
  // lands back on the pointer itself so a lone requester always wins.
  always_comb begin
    int cand;
    winner_onehot = '0;
    winner_idx    = '0;
    winner_valid  = 1'b0;
    cand          = 0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      cand = (int'(ptr) + k) % NUM_MASTERS;
      if (!winner_valid && req[cand]) begin
        winner_valid        = 1'b1;
        winner_onehot[cand] = 1'b1;
        winner_idx          = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// N-master to 1-slave round-robin bus arbiter. One transaction in flight;
// the winner's request fields are latched at grant and drive the slave until
// it acks, then ack/read data are steered back to that master only.
// Optional slave-ack watchdog enabled by defining ARBITER_TIMEOUT_EN.
module bus_arbiter_rr
  import bus_arbiter_rr_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int XLEN           = XLEN_DEFAULT,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [NUM_MASTERS-1:0]      i_bus_en,
  input  logic [NUM_MASTERS-1:0]      i_wr_rd,
  input  logic [NUM_MASTERS*XLEN-1:0] i_wr_data,
  input  logic [NUM_MASTERS*XLEN-1:0] i_addr,
  input  logic [NUM_MASTERS*F3_W-1:0] i_size,
  output logic [NUM_MASTERS-1:0]      o_ack,
  output logic [NUM_MASTERS*XLEN-1:0] o_rd_data,
  output logic [NUM_MASTERS-1:0]      o_grant,
  input  logic                        i_ack,
  input  logic [XLEN-1:0]             i_rd_data,
  output logic                        o_bus_en,
  output logic                        o_wr_rd,
  output logic [XLEN-1:0]             o_wr_data,
  output logic [XLEN-1:0]             o_addr,
  output logic [F3_W-1:0]             o_size,
  output logic                        o_err
);

  localparam int IDX_W = idx_width(NUM_MASTERS);

  bus_state_e             state_reg, state_next;
  logic [IDX_W-1:0]       ptr_reg, ptr_next;
  logic [NUM_MASTERS-1:0] grant_reg, grant_next;
  logic                   wr_rd_reg, wr_rd_next;
  logic [XLEN-1:0]        wr_data_reg, wr_data_next;
  logic [XLEN-1:0]        addr_reg, addr_next;
  logic [F3_W-1:0]        size_reg, size_next;

  logic [NUM_MASTERS-1:0] pick_onehot;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_valid;
  logic                   busy;
  logic                   done;
  logic                   slave_ack;

  rr_picker #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_W       (IDX_W)
  ) u_picker (
    .req           (i_bus_en),
    .ptr           (ptr_reg),
    .winner_onehot (pick_onehot),
    .winner_idx    (pick_idx),
    .winner_valid  (pick_valid)
  );

  assign busy      = (state_reg == ST_BUSY);
  assign slave_ack = busy & i_ack;

`ifdef ARBITER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             tmo_hit;

  // A real ack in the expiry cycle takes priority over the watchdog
  assign tmo_hit = busy & ~i_ack & (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
  assign done    = slave_ack | tmo_hit;
  assign o_err   = tmo_hit;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

  assign done  = slave_ack;
  assign o_err = 1'b0;
`endif

  // Next-state logic: grant and latch in IDLE, release on completion in BUSY
  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    grant_next   = grant_reg;
    wr_rd_next   = wr_rd_reg;
    wr_data_next = wr_data_reg;
    addr_next    = addr_reg;
    size_next    = size_reg;
`ifdef ARBITER_TIMEOUT_EN
    cnt_next     = cnt_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (pick_valid) begin
          state_next   = ST_BUSY;
          ptr_next     = pick_idx;
          grant_next   = pick_onehot;
          wr_rd_next   = i_wr_rd[pick_idx];
          wr_data_next = i_wr_data[int'(pick_idx)*XLEN +: XLEN];
          addr_next    = i_addr[int'(pick_idx)*XLEN +: XLEN];
          size_next    = i_size[int'(pick_idx)*F3_W +: F3_W];
`ifdef ARBITER_TIMEOUT_EN
          cnt_next     = '0;
`endif
        end
      end
      ST_BUSY: begin
        if (done) begin
          state_next = ST_IDLE;
          grant_next = '0;
        end
`ifdef ARBITER_TIMEOUT_EN
        else begin
          cnt_next = cnt_reg + 1'b1;
        end
`endif
      end
      default: begin
        state_next = ST_IDLE;
        grant_next = '0;
      end
    endcase
  end

  // State and latched request registers; reset parks the pointer on the
  // last master so master 0 is first in line
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_reg   <= ST_IDLE;
      ptr_reg     <= IDX_W'(NUM_MASTERS - 1);
      grant_reg   <= '0;
      wr_rd_reg   <= 1'b0;
      wr_data_reg <= '0;
      addr_reg    <= '0;
      size_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      grant_reg   <= grant_next;
      wr_rd_reg   <= wr_rd_next;
      wr_data_reg <= wr_data_next;
      addr_reg    <= addr_next;
      size_reg    <= size_next;
    end
  end

`ifdef ARBITER_TIMEOUT_EN
  // Watchdog counter of BUSY cycles without a slave ack
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end
`endif

  // Slave side is driven purely from latched fields
  assign o_bus_en  = busy;
  assign o_wr_rd   = wr_rd_reg;
  assign o_wr_data = wr_data_reg;
  assign o_addr    = addr_reg;
  assign o_size    = size_reg;
  assign o_grant   = grant_reg;

  // Per-master ack and read-data steering; only the granted slice is live,
  // and a watchdog completion returns zero data
  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_steer
    assign o_ack[gi] = done & grant_reg[gi];
    assign o_rd_data[gi*XLEN +: XLEN] = (slave_ack & grant_reg[gi]) ? i_rd_data : '0;
  end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Self-checking bench for bus_arbiter_rr (4 masters). Directed scenarios
// followed by random traffic, all checked against a transaction-level model.
// Define ARBITER_TIMEOUT_EN to exercise the watchdog path as well.
module tb_bus_arbiter_rr;

  localparam int N   = 4;
  localparam int XL  = 32;
  localparam int TMO = 8;
  localparam int DW  = N * XL;
`ifdef ARBITER_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic [N-1:0]  i_bus_en;
  logic [N-1:0]  i_wr_rd;
  logic [DW-1:0] i_wr_data;
  logic [DW-1:0] i_addr;
  logic [N*3-1:0] i_size;
  logic [N-1:0]  o_ack;
  logic [DW-1:0] o_rd_data;
  logic [N-1:0]  o_grant;
  logic          i_ack;
  logic [XL-1:0] i_rd_data;
  logic          o_bus_en;
  logic          o_wr_rd;
  logic [XL-1:0] o_wr_data;
  logic [XL-1:0] o_addr;
  logic [2:0]    o_size;
  logic          o_err;

  always #5 i_clk = ~i_clk;

  bus_arbiter_rr #(
    .NUM_MASTERS    (N),
    .XLEN           (XL),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_bus_en  (i_bus_en),
    .i_wr_rd   (i_wr_rd),
    .i_wr_data (i_wr_data),
    .i_addr    (i_addr),
    .i_size    (i_size),
    .o_ack     (o_ack),
    .o_rd_data (o_rd_data),
    .o_grant   (o_grant),
    .i_ack     (i_ack),
    .i_rd_data (i_rd_data),
    .o_bus_en  (o_bus_en),
    .o_wr_rd   (o_wr_rd),
    .o_wr_data (o_wr_data),
    .o_addr    (o_addr),
    .o_size    (o_size),
    .o_err     (o_err)
  );

  int compared   = 0;
  int mismatched = 0;

  // Transaction-level model: who owns the bus, what was latched, and who
  // was served last
  bit            m_busy;
  int            m_cur;
  int            m_last;
  int            m_cnt;
  logic          m_wr;
  logic [XL-1:0] m_wd;
  logic [XL-1:0] m_ad;
  logic [2:0]    m_sz;

  // Output samples taken at the checking point of the last tick
  logic [N-1:0]  s_ack;
  logic [DW-1:0] s_rd;
  logic          s_err;

  int order [5] = '{0, 1, 2, 3, 0};

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_cur  = 0;
    m_last = N - 1;
    m_cnt  = 0;
  endtask

  // One clock: check outputs at the falling edge, advance the model at the
  // rising edge, then return 1 time unit later for the next stimulus.
  task automatic tick();
    bit            tmo;
    bit            done;
    logic [N-1:0]  exp_ack;
    logic [DW-1:0] exp_rd;
    int            w;
    @(negedge i_clk);
    tmo     = TMO_EN && m_busy && !i_ack && (m_cnt == TMO - 1);
    done    = m_busy && (i_ack || tmo);
    exp_ack = done ? (N'(1) << m_cur) : '0;
    exp_rd  = '0;
    if (m_busy && i_ack) exp_rd[m_cur*XL +: XL] = i_rd_data;
    chk("bus_en", DW'(o_bus_en), DW'(m_busy));
    chk("grant", DW'(o_grant), m_busy ? DW'(N'(1) << m_cur) : DW'(0));
    chk("ack", DW'(o_ack), DW'(exp_ack));
    chk("rd_data", o_rd_data, exp_rd);
    chk("err", DW'(o_err), DW'(tmo));
    if (m_busy) begin
      chk("wr_rd", DW'(o_wr_rd), DW'(m_wr));
      chk("wr_data", DW'(o_wr_data), DW'(m_wd));
      chk("addr", DW'(o_addr), DW'(m_ad));
      chk("size", DW'(o_size), DW'(m_sz));
    end
    s_ack = o_ack;
    s_rd  = o_rd_data;
    s_err = o_err;
    @(posedge i_clk);
    if (!m_busy) begin
      w = -1;
      for (int k = 1; k <= N; k++) begin
        if (w < 0 && i_bus_en[(m_last + k) % N]) w = (m_last + k) % N;
      end
      if (w >= 0) begin
        m_busy = 1'b1;
        m_cur  = w;
        m_last = w;
        m_cnt  = 0;
        m_wr   = i_wr_rd[w];
        m_wd   = i_wr_data[w*XL +: XL];
        m_ad   = i_addr[w*XL +: XL];
        m_sz   = i_size[w*3 +: 3];
      end
    end else if (done) begin
      m_busy = 1'b0;
    end else begin
      m_cnt++;
    end
    #1;
  endtask

  initial begin
    int g;
    int n_busy;
    i_rst     = 1'b0;
    i_bus_en  = '0;
    i_wr_rd   = '0;
    i_wr_data = '0;
    i_addr    = '0;
    i_size    = '0;
    i_ack     = 1'b0;
    i_rd_data = '0;
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;

    // Reset state
    chk("rst_bus_en", DW'(o_bus_en), DW'(0));
    chk("rst_grant", DW'(o_grant), DW'(0));
    chk("rst_ack", DW'(o_ack), DW'(0));
    chk("rst_err", DW'(o_err), DW'(0));
    chk("rst_addr", DW'(o_addr), DW'(0));
    chk("rst_wr_data", DW'(o_wr_data), DW'(0));
    i_rst = 1'b1;

    // Master 0 read of 0x100, slave acks on the third BUSY cycle
    i_bus_en = 4'b0001;
    i_addr[0*XL +: XL] = 32'h100;
    i_size = 12'h222;
    tick();
    chk("t1_latency", DW'(o_bus_en), DW'(1));
    chk("t1_addr", DW'(o_addr), DW'(32'h100));
    tick();
    tick();
    i_ack     = 1'b1;
    i_rd_data = 32'hDEADBEEF;
    tick();
    chk("t1_ack", DW'(s_ack), DW'(4'b0001));
    chk("t1_rd0", DW'(s_rd[31:0]), DW'(32'hDEADBEEF));
    chk("t1_rd1", DW'(s_rd[63:32]), DW'(0));
    i_ack    = 1'b0;
    i_bus_en = '0;
    tick();

    // Slave ack pulse while idle is ignored
    i_ack = 1'b1;
    tick();
    chk("t4_idle_ack", DW'(s_ack), DW'(0));
    chk("t4_still_idle", DW'(o_bus_en), DW'(0));
    i_ack = 1'b0;

    // Asynchronous reset in the middle of a master 1 transaction
    i_bus_en = 4'b0010;
    tick();
    tick();
    i_bus_en = '0;
    i_ack    = 1'b1;
    i_rst    = 1'b0;
    #1;
    chk("t5_bus_en", DW'(o_bus_en), DW'(0));
    chk("t5_grant", DW'(o_grant), DW'(0));
    chk("t5_ack", DW'(o_ack), DW'(0));
    model_reset();
    tick();
    i_ack = 1'b0;
    i_rst = 1'b1;

    // All masters request, slave acks at once: rotation 0,1,2,3,0
    i_bus_en = 4'b1111;
    i_ack    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_grant_order", DW'(o_grant), DW'(N'(1) << order[i]));
      tick();
      chk("t2_dead_cycle", DW'(o_bus_en), DW'(0));
    end
    i_bus_en = '0;
    i_ack    = 1'b0;
    tick();

    // Master 2 write; request and address change under an open transaction
    i_bus_en = 4'b0100;
    i_wr_rd  = 4'b0100;
    i_wr_data[2*XL +: XL] = 32'h55;
    i_addr[2*XL +: XL]    = 32'h200;
    tick();
    i_bus_en = '0;
    i_addr[2*XL +: XL]    = 32'h300;
    i_wr_data[2*XL +: XL] = $urandom;
    tick();
    chk("t3_addr", DW'(o_addr), DW'(32'h200));
    chk("t3_wr_data", DW'(o_wr_data), DW'(32'h55));
    i_ack = 1'b1;
    tick();
    chk("t3_ack", DW'(s_ack), DW'(4'b0100));
    i_ack = 1'b0;
    tick();

`ifdef ARBITER_TIMEOUT_EN
    // Slave never answers: watchdog completes the transaction
    i_bus_en = 4'b1010;
    tick();
    g = m_cur;
    n_busy = 0;
    for (int i = 0; i < 20; i++) begin
      if (n_busy == 0 || !s_err) begin
        tick();
        n_busy++;
      end
    end
    chk("t6_err_seen", DW'(s_err), DW'(1));
    chk("t6_err_cycle", DW'(n_busy), DW'(TMO));
    chk("t6_ack", DW'(s_ack), DW'(N'(1) << g));
    chk("t6_rd_zero", s_rd, DW'(0));
    tick();
    chk("t6_next_grant", DW'(o_bus_en), DW'(1));
    i_bus_en = '0;
    i_ack    = 1'b1;
    tick();
    i_ack = 1'b0;
    tick();
`else
    g = 0;
    n_busy = 0;
`endif

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      i_bus_en  = N'($urandom);
      i_wr_rd   = N'($urandom);
      i_wr_data = {$urandom, $urandom, $urandom, $urandom};
      i_addr    = {$urandom, $urandom, $urandom, $urandom};
      i_size    = 12'($urandom);
      i_ack     = ($urandom_range(0, 2) == 0);
      i_rd_data = $urandom;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
